// File: rtl/id_exe_stage_reg.sv
// rtl/id_exe_stage_reg.sv - ID->EXE pipeline register with flush, freeze, write-back snoop and bubble counter
module id_exe_stage_reg #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  input  logic [DW-1:0]    pc_in,
  input  logic [DW-1:0]    val_rn_in,
  input  logic [DW-1:0]    val_rm_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic             wb_en_in,
  input  logic             mem_r_in,
  input  logic             mem_w_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic             imm_in,
  input  logic [11:0]      shift_op_in,
  input  logic [23:0]      simm24_in,
  input  logic [3:0]       status_in,
  input  logic             wb_en_snoop,
  input  logic [3:0]       wb_dest,
  input  logic [DW-1:0]    wb_value,
  output logic [DW-1:0]    pc_out,
  output logic [DW-1:0]    val_rn_out,
  output logic [DW-1:0]    val_rm_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       exe_cmd_out,
  output logic             wb_en_out,
  output logic             mem_r_out,
  output logic             mem_w_out,
  output logic             b_out,
  output logic             s_out,
  output logic             imm_out,
  output logic [11:0]      shift_op_out,
  output logic [23:0]      simm24_out,
  output logic [3:0]       status_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] bubble_count
);

  logic snoop_rn;
  logic snoop_rm;

  // Held operands track write-backs during a stall so EXE never sees stale data.
  assign snoop_rn = valid_out && wb_en_snoop && (wb_dest == src1_out);
  assign snoop_rm = valid_out && wb_en_snoop && (wb_dest == src2_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      pc_out       <= '0;
      val_rn_out   <= '0;
      val_rm_out   <= '0;
      src1_out     <= '0;
      src2_out     <= '0;
      dest_out     <= '0;
      exe_cmd_out  <= '0;
      wb_en_out    <= 1'b0;
      mem_r_out    <= 1'b0;
      mem_w_out    <= 1'b0;
      b_out        <= 1'b0;
      s_out        <= 1'b0;
      imm_out      <= 1'b0;
      shift_op_out <= '0;
      simm24_out   <= '0;
      status_out   <= '0;
      valid_out    <= 1'b0;
    end else if (freeze) begin
      if (snoop_rn) val_rn_out <= wb_value;
      if (snoop_rm) val_rm_out <= wb_value;
    end else begin
      pc_out       <= pc_in;
      val_rn_out   <= val_rn_in;
      val_rm_out   <= val_rm_in;
      src1_out     <= src1_in;
      src2_out     <= src2_in;
      dest_out     <= dest_in;
      exe_cmd_out  <= exe_cmd_in;
      wb_en_out    <= wb_en_in;
      mem_r_out    <= mem_r_in;
      mem_w_out    <= mem_w_in;
      b_out        <= b_in;
      s_out        <= s_in;
      imm_out      <= imm_in;
      shift_op_out <= shift_op_in;
      simm24_out   <= simm24_in;
      status_out   <= status_in;
      valid_out    <= 1'b1;
    end
  end

  // Saturating so a long flush storm never wraps back to a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (flush && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

endmodule
